arp_request_parser: RTL and testbench

Receive-side ARP stage feeding the ARP reply transmitter. Consumes the byte stream of received Ethernet frames from the GbE client, recognises ARP requests addressed to the local IP, and builds the 28-byte ARP reply payload on `arp_tx_reply_frame`. It then holds `arp_req` until the transmitter acknowledges with `arp_reply`. Frames arriving while a reply is outstanding are dropped and counted.

---
 rtl/arp_request_parser.sv | 185 ++++++++++++++++++
 tb/tb_arp_request_parser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/arp_request_parser.sv
// Receive-side ARP request recogniser: parses GbE client frames, builds the
// 28-byte ARP reply payload and handshakes it to the reply transmitter.
module arp_request_parser #(
  parameter logic [5:0] MinBytes = 6'd42
) (
  input  logic         arp_wr_clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_data_valid,
  input  logic         rx_good_frame,
  input  logic         rx_bad_frame,
  input  logic [47:0]  local_mac,
  input  logic [31:0]  local_ip,
  output logic         arp_req,
  input  logic         arp_reply,
  output logic [223:0] arp_tx_reply_frame,
  output logic [15:0]  arp_rx_cnt,
  output logic [15:0]  arp_drop_cnt
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PARSE = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic         mism_q, mism_d;
  logic         bc_bad_q, bc_bad_d;
  logic         uc_bad_q, uc_bad_d;
  logic         mid_q, mid_d;
  logic [47:0]  sha_q, sha_d;
  logic [31:0]  spa_q, spa_d;
  logic         req_q, req_d;
  logic [223:0] frame_q, frame_d;
  logic [15:0]  rx_cnt_q, rx_cnt_d;
  logic [15:0]  drop_q, drop_d;

  logic         first;
  logic [5:0]   bi;
  logic         chk;
  logic [7:0]   exp_b;
  logic [7:0]   mac_b;
  logic         match;
  logic         busy;

  // A byte seen outside a frame is byte 0; otherwise the running index applies.
  assign first = rx_data_valid && !mid_q;
  assign bi    = first ? 6'd0 : idx_q;
  assign busy  = (state_q == ST_REQ) || (state_q == ST_ACK);

  always_comb begin
    chk   = 1'b1;
    exp_b = 8'h00;
    mac_b = 8'h00;
    case (bi)
      6'd0:  begin chk = 1'b0; mac_b = local_mac[47:40]; end
      6'd1:  begin chk = 1'b0; mac_b = local_mac[39:32]; end
      6'd2:  begin chk = 1'b0; mac_b = local_mac[31:24]; end
      6'd3:  begin chk = 1'b0; mac_b = local_mac[23:16]; end
      6'd4:  begin chk = 1'b0; mac_b = local_mac[15:8];  end
      6'd5:  begin chk = 1'b0; mac_b = local_mac[7:0];   end
      6'd12: exp_b = 8'h08;
      6'd13: exp_b = 8'h06;
      6'd14: exp_b = 8'h00;
      6'd15: exp_b = 8'h01;
      6'd16: exp_b = 8'h08;
      6'd17: exp_b = 8'h00;
      6'd18: exp_b = 8'h06;
      6'd19: exp_b = 8'h04;
      6'd20: exp_b = 8'h00;
      6'd21: exp_b = 8'h01;
      6'd38: exp_b = local_ip[31:24];
      6'd39: exp_b = local_ip[23:16];
      6'd40: exp_b = local_ip[15:8];
      6'd41: exp_b = local_ip[7:0];
      default: chk = 1'b0;
    endcase
  end

  // Destination MAC passes if all six bytes are FF or all six match local_mac,
  // so broadcast and unicast mismatches are tracked separately.
  always_comb begin
    idx_d    = idx_q;
    mism_d   = mism_q;
    bc_bad_d = bc_bad_q;
    uc_bad_d = uc_bad_q;
    sha_d    = sha_q;
    spa_d    = spa_q;
    if (rx_data_valid) begin
      if (first) begin
        idx_d    = 6'd1;
        mism_d   = 1'b0;
        bc_bad_d = 1'b0;
        uc_bad_d = 1'b0;
      end else if (idx_q != 6'd63) begin
        idx_d = idx_q + 6'd1;
      end
      if (bi < 6'd6) begin
        bc_bad_d = bc_bad_d | (rx_data != 8'hFF);
        uc_bad_d = uc_bad_d | (rx_data != mac_b);
      end
      if (chk && (rx_data != exp_b)) mism_d = 1'b1;
      if (bi >= 6'd22 && bi <= 6'd27) sha_d = {sha_q[39:0], rx_data};
      if (bi >= 6'd28 && bi <= 6'd31) spa_d = {spa_q[23:0], rx_data};
    end
  end

  // Evaluated on next-state values so a byte sharing the strobe cycle counts.
  assign match = !mism_d && !(bc_bad_d && uc_bad_d) && (idx_d >= MinBytes);

  always_comb begin
    if (rx_good_frame || rx_bad_frame) mid_d = 1'b0;
    else if (rx_data_valid)            mid_d = 1'b1;
    else                               mid_d = mid_q;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    frame_d  = frame_q;
    rx_cnt_d = rx_cnt_q;
    drop_d   = drop_q;
    case (state_q)
      ST_IDLE: if (first) state_d = ST_PARSE;
      ST_PARSE: begin
        if (rx_bad_frame) begin
          state_d = ST_IDLE;
        end else if (rx_good_frame) begin
          if (match) begin
            frame_d  = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                        local_mac, local_ip, sha_d, spa_d};
            req_d    = 1'b1;
            rx_cnt_d = rx_cnt_q + 16'd1;
            state_d  = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_REQ: if (arp_reply) begin
        req_d   = 1'b0;
        state_d = ST_ACK;
      end
      // Holding here until arp_reply drops keeps its tail from acking a new request.
      ST_ACK: if (!arp_reply) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (busy && rx_good_frame && !rx_bad_frame && match) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge arp_wr_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 6'd0;
      mism_q   <= 1'b0;
      bc_bad_q <= 1'b0;
      uc_bad_q <= 1'b0;
      mid_q    <= 1'b0;
      sha_q    <= 48'd0;
      spa_q    <= 32'd0;
      req_q    <= 1'b0;
      frame_q  <= 224'd0;
      rx_cnt_q <= 16'd0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mism_q   <= mism_d;
      bc_bad_q <= bc_bad_d;
      uc_bad_q <= uc_bad_d;
      mid_q    <= mid_d;
      sha_q    <= sha_d;
      spa_q    <= spa_d;
      req_q    <= req_d;
      frame_q  <= frame_d;
      rx_cnt_q <= rx_cnt_d;
      drop_q   <= drop_d;
    end
  end

  assign arp_req            = req_q;
  assign arp_tx_reply_frame = frame_q;
  assign arp_rx_cnt         = rx_cnt_q;
  assign arp_drop_cnt       = drop_q;
endmodule

// File: tb/tb_arp_request_parser.sv
// Directed bench for arp_request_parser: hand-built frames, hand-computed replies.
module tb_arp_request_parser;
  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_data_valid, rx_good_frame, rx_bad_frame;
  logic [47:0]  local_mac;
  logic [31:0]  local_ip;
  logic         arp_req, arp_reply;
  logic [223:0] arp_tx_reply_frame;
  logic [15:0]  arp_rx_cnt, arp_drop_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] fr [0:63];

  localparam logic [47:0] LMAC = 48'h02AABBCCDDEE;
  localparam logic [31:0] LIP  = 32'hC0A80102;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SHA1 = 48'h001122334455;
  localparam logic [31:0] SPA1 = 32'hC0A80105;
  localparam logic [47:0] SHA2 = 48'h0A0B0C0D0E0F;
  localparam logic [31:0] SPA2 = 32'hC0A80107;
  localparam logic [223:0] EXP1 =
    224'h0001_0800_06_04_0002_02AABBCCDDEE_C0A80102_001122334455_C0A80105;
  localparam logic [223:0] EXP2 =
    224'h0001_0800_06_04_0002_02AABBCCDDEE_C0A80102_0A0B0C0D0E0F_C0A80107;

  arp_request_parser #(.MinBytes(6'd42)) dut (
    .arp_wr_clk(clk), .reset(reset), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_good_frame(rx_good_frame),
    .rx_bad_frame(rx_bad_frame), .local_mac(local_mac), .local_ip(local_ip),
    .arp_req(arp_req), .arp_reply(arp_reply),
    .arp_tx_reply_frame(arp_tx_reply_frame), .arp_rx_cnt(arp_rx_cnt),
    .arp_drop_cnt(arp_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] op, input logic [47:0] s,
                       input logic [31:0] sp, input logic [31:0] tp);
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]      = dst[47-8*i -: 8];
      fr[6+i]    = s[47-8*i -: 8];
      fr[22+i]   = s[47-8*i -: 8];
    end
    fr[12] = 8'h08; fr[13] = 8'h06; fr[14] = 8'h00; fr[15] = 8'h01;
    fr[16] = 8'h08; fr[17] = 8'h00; fr[18] = 8'h06; fr[19] = 8'h04;
    fr[20] = op[15:8]; fr[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[28+i] = sp[31-8*i -: 8];
      fr[38+i] = tp[31-8*i -: 8];
    end
  endtask

  task automatic send_bytes(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      rx_data = fr[i];
      rx_data_valid = 1'b1;
    end
  endtask

  task automatic strobe(input bit good);
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    rx_good_frame = good;
    rx_bad_frame = !good;
    @(negedge clk);
    rx_good_frame = 1'b0;
    rx_bad_frame = 1'b0;
  endtask

  // Transmitter ack: 3 cycles high; arp_req must fall after the first.
  task automatic do_reply(input string tag, input logic [223:0] ef);
    @(negedge clk);
    arp_reply = 1'b1;
    @(negedge clk);
    check({tag, "_req_drop"}, 224'(arp_req), 224'(0));
    @(negedge clk);
    check({tag, "_frame_hold"}, arp_tx_reply_frame, ef);
    @(negedge clk);
    arp_reply = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_data_valid = 1'b0;
    rx_good_frame = 1'b0; rx_bad_frame = 1'b0; arp_reply = 1'b0;
    local_mac = LMAC; local_ip = LIP;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req", 224'(arp_req), 224'(0));
    check("rst_frame", arp_tx_reply_frame, 224'(0));
    check("rst_rxcnt", 224'(arp_rx_cnt), 224'(0));
    check("rst_dropcnt", 224'(arp_drop_cnt), 224'(0));

    // Broadcast request, 60 bytes
    build(BC, 16'h0001, SHA1, SPA1, LIP);
    send_bytes(0, 59);
    check("bc_req_before", 224'(arp_req), 224'(0));
    strobe(1'b1);
    check("bc_req", 224'(arp_req), 224'(1));
    check("bc_frame", arp_tx_reply_frame, EXP1);
    check("bc_rxcnt", 224'(arp_rx_cnt), 224'(1));
    do_reply("bc", EXP1);

    // Unicast to local_mac at the 42-byte minimum
    build(LMAC, 16'h0001, SHA2, SPA2, LIP);
    send_bytes(0, 41);
    strobe(1'b1);
    check("uc42_req", 224'(arp_req), 224'(1));
    check("uc42_frame", arp_tx_reply_frame, EXP2);
    check("uc42_rxcnt", 224'(arp_rx_cnt), 224'(2));
    do_reply("uc42", EXP2);

    build(BC, 16'h0001, SHA1, SPA1, 32'hC0A80199);
    send_bytes(0, 59); strobe(1'b1);
    check("tpa_req", 224'(arp_req), 224'(0));
    check("tpa_rxcnt", 224'(arp_rx_cnt), 224'(2));

    build(48'h02AABBCCDDEF, 16'h0001, SHA1, SPA1, LIP);
    send_bytes(0, 59); strobe(1'b1);
    check("dst_req", 224'(arp_req), 224'(0));

    build(BC, 16'h0002, SHA1, SPA1, LIP);
    send_bytes(0, 59); strobe(1'b1);
    check("op_req", 224'(arp_req), 224'(0));

    build(BC, 16'h0001, SHA1, SPA1, LIP);
    send_bytes(0, 40); strobe(1'b1);
    check("len41_req", 224'(arp_req), 224'(0));

    send_bytes(0, 59); strobe(1'b0);
    check("bad_req", 224'(arp_req), 224'(0));
    check("neg_rxcnt", 224'(arp_rx_cnt), 224'(2));
    check("neg_dropcnt", 224'(arp_drop_cnt), 224'(0));

    // Busy drop: second request arrives while the first is unacknowledged
    send_bytes(0, 59); strobe(1'b1);
    check("busy1_rxcnt", 224'(arp_rx_cnt), 224'(3));
    build(BC, 16'h0001, 48'h66778899AABB, SPA2, LIP);
    send_bytes(0, 59); strobe(1'b1);
    check("busy_dropcnt", 224'(arp_drop_cnt), 224'(1));
    check("busy_frame", arp_tx_reply_frame, EXP1);
    check("busy_req", 224'(arp_req), 224'(1));
    check("busy_rxcnt", 224'(arp_rx_cnt), 224'(3));
    do_reply("busy", EXP1);
    build(BC, 16'h0001, SHA2, SPA2, LIP);
    send_bytes(0, 59); strobe(1'b1);
    check("third_rxcnt", 224'(arp_rx_cnt), 224'(4));
    check("third_frame", arp_tx_reply_frame, EXP2);
    do_reply("third", EXP2);

    // Reset while byte 20 is on the bus
    build(BC, 16'h0001, SHA1, SPA1, LIP);
    send_bytes(0, 19);
    @(negedge clk);
    rx_data = fr[20]; rx_data_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rx_data_valid = 1'b0;
    check("mrst_req", 224'(arp_req), 224'(0));
    check("mrst_frame", arp_tx_reply_frame, 224'(0));
    check("mrst_rxcnt", 224'(arp_rx_cnt), 224'(0));
    check("mrst_dropcnt", 224'(arp_drop_cnt), 224'(0));
    send_bytes(21, 59); strobe(1'b1);
    check("mrst_tail_req", 224'(arp_req), 224'(0));
    check("mrst_tail_rxcnt", 224'(arp_rx_cnt), 224'(0));
    send_bytes(0, 59); strobe(1'b1);
    check("post_rst_req", 224'(arp_req), 224'(1));
    check("post_rst_frame", arp_tx_reply_frame, EXP1);
    check("post_rst_rxcnt", 224'(arp_rx_cnt), 224'(1));
    do_reply("post_rst", EXP1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
